difftest_clock_gate_ctrl: RTL and testbench

- Enable controller directly upstream of the difftest clock-gate cell. Its en_out drives the gate's enable input.
- Watches difftest activity and downstream busy status. Keeps the gated difftest clock running for a hold-off window after the last activity, waits for the downstream to drain, then shuts the clock off. Wakes it on the next activity.
- Retimes the enable onto the falling edge, so a CK&E gate never produces a truncated pulse.
- Provides a saturating gated-cycle counter for performance reporting.

---
 rtl/difftest_cg_pkg.sv | 14 +
 rtl/difftest_sat_counter.sv | 23 ++
 rtl/difftest_clock_gate_ctrl.sv | 110 +++++++++++
 tb/tb_difftest_clock_gate_ctrl.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/difftest_cg_pkg.sv
// Shared types and constants for the difftest clock-gate enable controller.
// Holds the FSM state encoding and the default statistic counter width.
package difftest_cg_pkg;

    typedef enum logic [1:0] {
        CG_ON    = 2'd0,
        CG_HOLD  = 2'd1,
        CG_DRAIN = 2'd2,
        CG_OFF   = 2'd3
    } cg_state_e;

    localparam int CG_STAT_W = 32;

endpackage

// File: rtl/difftest_sat_counter.sv
// Saturating up-counter with synchronous clear; clear wins over increment.
// Ports: clock, reset_n (async low), inc, clear, count[W-1:0].
module difftest_sat_counter #(
    parameter int W = 32
) (
    input  logic         clock,
    input  logic         reset_n,
    input  logic         inc,
    input  logic         clear,
    output logic [W-1:0] count
);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/difftest_clock_gate_ctrl.sv
// Enable controller for the difftest clock gate: hold-off, drain, gate-off, wake.
// Ports: clock, reset_n, activity, force_on, gate_allow, busy, stat_clear in;
//        en_out (negedge-retimed), state_out, gated_cycles out.
module difftest_clock_gate_ctrl
    import difftest_cg_pkg::*;
#(
    parameter int HOLD_CYCLES = 16,
    parameter int STAT_W      = CG_STAT_W
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              activity,
    input  logic              force_on,
    input  logic              gate_allow,
    input  logic              busy,
    input  logic              stat_clear,
    output logic              en_out,
    output logic [1:0]        state_out,
    output logic [STAT_W-1:0] gated_cycles
);

    localparam int CNT_W = (HOLD_CYCLES > 0) ? $clog2(HOLD_CYCLES + 1) : 1;
    localparam int LOAD_V = (HOLD_CYCLES > 0) ? HOLD_CYCLES - 1 : 0;
    localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(LOAD_V);

    cg_state_e        state;
    cg_state_e        state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;
    logic             en_q;
    logic             wake;

    assign wake = activity | force_on | ~gate_allow;

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        unique case (state)
            CG_ON: begin
                if (wake) begin
                    state_nxt = CG_ON;
                end else if (HOLD_CYCLES > 0) begin
                    state_nxt = CG_HOLD;
                    cnt_nxt   = HOLD_LOAD;
                end else begin
                    state_nxt = CG_DRAIN;
                end
            end
            CG_HOLD: begin
                if (wake) begin
                    state_nxt = CG_ON;
                end else if (cnt == '0) begin
                    state_nxt = CG_DRAIN;
                end else begin
                    cnt_nxt = cnt - 1'b1;
                end
            end
            CG_DRAIN: begin
                if (wake) begin
                    state_nxt = CG_ON;
                end else if (!busy) begin
                    state_nxt = CG_OFF;
                end
            end
            CG_OFF: begin
                if (wake) begin
                    state_nxt = CG_ON;
                end
            end
            default: begin
                state_nxt = CG_ON;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state <= CG_ON;
            cnt   <= '0;
            en_q  <= 1'b1;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            en_q  <= (state_nxt != CG_OFF);
        end
    end

    // Falling-edge retime: the enable only moves while the clock is low,
    // so the AND-type gate never slices a high phase.
    always_ff @(negedge clock or negedge reset_n) begin
        if (!reset_n) begin
            en_out <= 1'b1;
        end else begin
            en_out <= en_q;
        end
    end

    assign state_out = state;

    difftest_sat_counter #(
        .W(STAT_W)
    ) u_gated_cnt (
        .clock  (clock),
        .reset_n(reset_n),
        .inc    (~en_q),
        .clear  (stat_clear),
        .count  (gated_cycles)
    );

endmodule

// File: tb/tb_difftest_clock_gate_ctrl.sv
// Scoreboard bench for difftest_clock_gate_ctrl: two instances
// (HOLD=16/STAT_W=32 and HOLD=0/STAT_W=4) against an idle-count reference model.
module tb_difftest_clock_gate_ctrl;

    logic        clock;
    logic        reset_n;
    logic        activity;
    logic        force_on;
    logic        gate_allow;
    logic        busy;
    logic        stat_clear;
    logic        en0;
    logic        en1;
    logic [1:0]  st0;
    logic [1:0]  st1;
    logic [31:0] gc0;
    logic [3:0]  gc1;

    int compared;
    int mismatched;
    bit run;

    difftest_clock_gate_ctrl #(
        .HOLD_CYCLES(16),
        .STAT_W     (32)
    ) dut0 (
        .clock       (clock),
        .reset_n     (reset_n),
        .activity    (activity),
        .force_on    (force_on),
        .gate_allow  (gate_allow),
        .busy        (busy),
        .stat_clear  (stat_clear),
        .en_out      (en0),
        .state_out   (st0),
        .gated_cycles(gc0)
    );

    difftest_clock_gate_ctrl #(
        .HOLD_CYCLES(0),
        .STAT_W     (4)
    ) dut1 (
        .clock       (clock),
        .reset_n     (reset_n),
        .activity    (activity),
        .force_on    (force_on),
        .gate_allow  (gate_allow),
        .busy        (busy),
        .stat_clear  (stat_clear),
        .en_out      (en1),
        .state_out   (st1),
        .gated_cycles(gc1)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Reference: n = consecutive non-wake edges. n==0 ON, 1..HOLD in HOLD,
    // HOLD+1 entering DRAIN, beyond that DRAIN until busy is seen low.
    typedef struct {
        int     n;
        int     st;
        longint g;
    } mdl_t;

    typedef struct {
        int     st;
        bit     en;
        longint g;
    } exp_t;

    mdl_t m0;
    mdl_t m1;
    exp_t q0[$];
    exp_t q1[$];

    function automatic mdl_t step(mdl_t m, bit wake, bit bs, bit clr,
                                  int hold, longint maxv);
        mdl_t r;
        bit   prev_off;
        r = m;
        prev_off = (m.st == 3);
        if (wake) r.n = 0;
        else if (m.n < 100000) r.n = m.n + 1;
        if (r.n == 0) r.st = 0;
        else if (r.n <= hold) r.st = 1;
        else if (r.n == hold + 1) r.st = 2;
        else r.st = (prev_off || !bs) ? 3 : 2;
        if (clr) r.g = 0;
        else if (prev_off && m.g < maxv) r.g = m.g + 1;
        return r;
    endfunction

    function automatic exp_t to_exp(mdl_t m);
        exp_t e;
        e.st = m.st;
        e.en = (m.st != 3);
        e.g  = m.g;
        return e;
    endfunction

    task automatic chk(string nm, longint got, longint want);
        compared++;
        if (got != want) begin
            mismatched++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, got, want, $time);
        end
    endtask

    always @(posedge clock) begin
        if (run && reset_n) begin
            bit w;
            w = activity | force_on | !gate_allow;
            m0 = step(m0, w, busy, stat_clear, 16, 64'hFFFF_FFFF);
            m1 = step(m1, w, busy, stat_clear, 0, 15);
            q0.push_back(to_exp(m0));
            q1.push_back(to_exp(m1));
        end
    end

    always @(negedge clock) begin
        #1;
        if (q0.size() > 0) begin
            exp_t e;
            e = q0.pop_front();
            chk("i0_state", st0, e.st);
            chk("i0_en", en0, e.en);
            chk("i0_gated", gc0, e.g);
        end
        if (q1.size() > 0) begin
            exp_t e;
            e = q1.pop_front();
            chk("i1_state", st1, e.st);
            chk("i1_en", en1, e.en);
            chk("i1_gated", gc1, e.g);
        end
    end

    task automatic drive(bit a, bit f, bit g, bit b, bit c);
        @(posedge clock);
        #2;
        activity   = a;
        force_on   = f;
        gate_allow = g;
        busy       = b;
        stat_clear = c;
    endtask

    task automatic idle(int n, bit b);
        for (int i = 0; i < n; i++) drive(0, 0, 1, b, 0);
    endtask

    task automatic rnd(int n, int pa, int pb, int pf, int pg, int pc);
        for (int i = 0; i < n; i++) begin
            drive($urandom_range(99) < pa, $urandom_range(99) < pf,
                  !($urandom_range(99) < pg), $urandom_range(99) < pb,
                  $urandom_range(99) < pc);
        end
    endtask

    initial begin
        compared   = 0;
        mismatched = 0;
        run        = 0;
        m0 = '{n: 0, st: 0, g: 0};
        m1 = '{n: 0, st: 0, g: 0};
        activity   = 0;
        force_on   = 0;
        gate_allow = 1;
        busy       = 0;
        stat_clear = 0;
        reset_n    = 1;
        #1 reset_n = 0;
        #2;
        chk("rst_en0", en0, 1);
        chk("rst_en1", en1, 1);
        chk("rst_st0", st0, 0);
        chk("rst_gc0", gc0, 0);
        chk("rst_gc1", gc1, 0);
        #9;
        reset_n = 1;
        run = 1;
        idle(60, 0);
        drive(1, 0, 1, 0, 0);
        idle(30, 0);
        drive(1, 0, 1, 0, 0);
        idle(11, 0);
        drive(1, 0, 1, 0, 0);
        idle(16, 0);
        drive(1, 0, 1, 0, 0);
        idle(40, 0);
        drive(1, 0, 1, 1, 0);
        idle(60, 1);
        idle(10, 0);
        for (int i = 0; i < 100; i++) drive(0, 1, 1, 0, 0);
        idle(30, 0);
        for (int i = 0; i < 100; i++) drive(0, 0, 0, 0, 0);
        idle(30, 0);
        drive(0, 0, 1, 0, 1);
        idle(25, 0);
        rnd(400, 4, 40, 1, 1, 2);
        rnd(300, 15, 60, 3, 3, 5);
        idle(40, 0);
        @(negedge clock);
        run = 0;
        #3;
        chk("off_en0", en0, 0);
        chk("off_en1", en1, 0);
        reset_n = 0;
        #1;
        chk("async_en0", en0, 1);
        chk("async_en1", en1, 1);
        chk("async_st0", st0, 0);
        chk("async_gc1", gc1, 0);
        #6 reset_n = 1;
        @(posedge clock);
        #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
